// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and constants for the fetch/data SRAM arbiter.
//   owner_t   - which port the SRAM response in flight belongs to
//   GNT_INST  - bit index of the fetch port in the 2-bit req/grant vectors
//   GNT_DATA  - bit index of the data port in the 2-bit req/grant vectors
//   STARVE_W  - width of the fetch starvation counter
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_W       = 4;
    localparam int STARVE_MAX_DEF = 4;

    localparam int GNT_INST = 0;
    localparam int GNT_DATA = 1;

endpackage : sram_arb_pkg

// File: rtl/arb_grant2.sv
// ---------------------------------------------------------------------------
// arb_grant2
// Pure combinational 2-way grant. A lone requester always wins. When both
// request, prio_inst picks the fetch port, otherwise the data port wins.
// The top derives prio_inst from its policy state (starvation counter in
// fixed-priority mode, last grant when ARB_RR_EN is defined).
//   req[1:0]    in   request vector, indexed by GNT_INST / GNT_DATA
//   prio_inst   in   fetch port wins a contested cycle
//   grant[1:0]  out  one-hot grant, all zero when nothing requests
// ---------------------------------------------------------------------------
module arb_grant2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio_inst,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[GNT_INST] && (prio_inst || !req[GNT_DATA])) begin
            grant[GNT_INST] = 1'b1;
        end else if (req[GNT_DATA]) begin
            grant[GNT_DATA] = 1'b1;
        end
    end

endmodule : arb_grant2

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// CPU fetch port and data port. At most one request is accepted per cycle;
// the accepted master's fields drive the SRAM that same cycle and the read
// data is routed back to it on the following cycle.
//
// Build option: define ARB_RR_EN for round-robin arbitration. Without it the
// data port has fixed priority and a waiting fetch is forced through after
// STARVE_MAX consecutive lost cycles.
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   inst_req/addr                  fetch request (read only)
//   inst_addr_ok                   fetch request accepted this cycle
//   inst_data_ok/rdata             fetch response, one cycle after accept
//   data_req/we/addr/wdata         data request
//   data_addr_ok                   data request accepted this cycle
//   data_data_ok/rdata             data response (rdata is 0 for writes)
//   sram_en/we/addr/wdata          SRAM command
//   sram_rdata                     SRAM read data, valid cycle after sram_en
// ---------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
)
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    logic [1:0] req;
    logic [1:0] grant;
    logic       prio_inst;
    logic       inst_acc;
    logic       data_acc;
    owner_t     owner;
    owner_t     owner_next;
    logic       resp_we;

    assign req = {data_req, inst_req};

    arb_grant2 u_grant (
        .req       (req),
        .prio_inst (prio_inst),
        .grant     (grant)
    );

    // Grants are only ever raised for a requesting port, so a grant is an
    // accept. Gating with resetn keeps every strobe low while in reset.
    assign inst_acc = resetn & grant[GNT_INST];
    assign data_acc = resetn & grant[GNT_DATA];

`ifdef ARB_RR_EN
    // Round-robin: remember who won the most recent accept; in a contested
    // cycle the other port wins.
    owner_t last_grant;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant <= OWN_INST;
        end else if (data_acc) begin
            last_grant <= OWN_DATA;
        end else if (inst_acc) begin
            last_grant <= OWN_INST;
        end
    end

    assign prio_inst = (last_grant == OWN_DATA);
`else
    // Fixed priority with a starvation guard: count consecutive cycles the
    // fetch port requested and lost; at the limit the fetch is forced through.
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve <= '0;
        end else if (!inst_req || inst_acc) begin
            starve <= '0;
        end else if (starve != STARVE_LIM) begin
            starve <= starve + 1'b1;
        end
    end

    assign prio_inst = (starve == STARVE_LIM);
`endif

    // Command mux toward the SRAM and response-owner next state.
    always_comb begin
        inst_addr_ok = inst_acc;
        data_addr_ok = data_acc;
        sram_en      = inst_acc | data_acc;
        sram_we      = data_acc & data_we;
        sram_addr    = '0;
        sram_wdata   = '0;
        owner_next   = OWN_NONE;
        if (data_acc) begin
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
            owner_next = OWN_DATA;
        end else if (inst_acc) begin
            sram_addr  = inst_addr;
            owner_next = OWN_INST;
        end
    end

    // The owner register tags the SRAM output for the cycle after an accept;
    // resp_we marks a data-port write so no read data is returned for it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner   <= OWN_NONE;
            resp_we <= 1'b0;
        end else begin
            owner   <= owner_next;
            resp_we <= data_acc & data_we;
        end
    end

    // Response routing; gated by resetn so an in-flight response is dropped.
    always_comb begin
        inst_data_ok = resetn && (owner == OWN_INST);
        data_data_ok = resetn && (owner == OWN_DATA);
        inst_rdata   = '0;
        data_rdata   = '0;
        if (inst_data_ok) begin
            inst_rdata = sram_rdata;
        end
        if (data_data_ok && !resp_we) begin
            data_rdata = sram_rdata;
        end
    end

endmodule : sram_arbiter

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one single-port synchronous SRAM between the CPU instruction-fetch port and data-access port, so a unified-memory mini CPU can run on one RAM macro. Each side uses a req / addr_ok / data_ok handshake. The arbiter grants at most one request per cycle and routes the 1-cycle-latency read data back to the winning port. It sits between the CPU core's fetch/load-store logic and the memory.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive lost cycles after which a waiting fetch is forced to win (fixed-priority mode only); legal range 1..15

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- inst_req  in  1  fetch request
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request
- data_we  in  1  1 = write, 0 = read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  read data valid, or write complete
- data_rdata  out  DATA_W  read data
- sram_en  out  1  SRAM access strobe
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data; valid the cycle after sram_en

## Operation
- A master holds req, addr, we and wdata stable until it sees addr_ok.
- Accept = req & addr_ok, evaluated in the same cycle.
- Grant is combinational from the reqs and the arbiter state. Exactly one of inst_addr_ok / data_addr_ok is high when any req is high; both are low when no req is high.
- In the accept cycle, the granted master's fields drive the sram_* outputs and sram_en is 1. When there is no grant: sram_en = 0, sram_we = 0, addr/wdata are don't-care (driven 0).
- inst is read-only; sram_we = data_we only on a data grant.
- Response tracker `owner`: NONE / INST / DATA.
  - Next state is the winner of the accept this cycle, or NONE if there was no accept.
  - owner = INST: inst_data_ok = 1, inst_rdata = sram_rdata.
  - owner = DATA: data_data_ok = 1, data_rdata = sram_rdata, or don't-care (0) for a write.
- Back-to-back accepts are allowed every cycle. There is no response backpressure; masters must consume data_ok in the cycle it appears.
- Default policy (fixed priority): data beats inst.
  - Starvation counter `starve` (4 bits) increments each cycle inst_req = 1 and loses.
  - When starve == STARVE_MAX and inst_req = 1, inst wins regardless of data_req.
  - starve clears on an inst accept or when inst_req = 0.
  - starve saturates at STARVE_MAX.

## Timing
- Reset values: owner = NONE, starve = 0, last-grant = INST.
  - While resetn = 0, all *_addr_ok, *_data_ok and sram_en/sram_we are forced to 0, and rdata outputs are 0.
- Latency: accept in cycle T, data_ok and rdata in cycle T+1. Throughput is one access per cycle.
- Simultaneous reqs: one winner per policy. The loser's addr_ok stays 0 and it re-competes in T+1.
- A new accept in T+1 may coincide with the T response; both are legal.
- Reset mid-operation: an in-flight response is dropped (no data_ok after reset), and arbitration state returns to its reset values.
- Single requester: granted every cycle, with no bubble.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - With both reqs high, the winner is the master that did not win the last contested-or-uncontested accept.
  - Last-grant updates on every accept.
  - The starvation counter and STARVE_MAX are unused; starve is held at 0.
- ARB_RR_EN undefined: fixed priority data > inst, with the starvation guard as above.

## Structure
- Package sram_arb_pkg holds:
  - the owner enum (OWN_NONE, OWN_INST, OWN_DATA)
  - the default widths
  - STARVE_W = 4
- Sub-module arb_grant2 holds the pure 2-way grant logic:
  - inputs: req[1:0], policy state
  - output: one-hot grant[1:0]
  - The top keeps the owner, starve and last-grant registers, plus the mux/route logic.

## Test plan
- Only inst_req = 1, addrs 0x1c000000, 0x1c000004, 0x1c000008 over consecutive cycles -> inst_addr_ok = 1 each cycle, and inst_data_ok in cycles T+1..T+3 carries the SRAM contents.
- Data write 0x100 <= 0xdeadbeef, then read 0x100 -> sram_we = 1 on the first accept; data_data_ok on both responses; read returns 0xdeadbeef.
- Both reqs held high for 10 cycles, fixed priority, STARVE_MAX = 4 -> data wins 4 cycles, inst wins on the 5th, and the pattern repeats.
- Both reqs held high, ARB_RR_EN defined -> grants alternate data/inst each cycle, starting with data (last-grant reset = INST).
- Data read accepted in cycle T, resetn = 0 in T+1 -> no data_data_ok; after release, owner = NONE and the first request is accepted normally.
- No requests -> sram_en = 0 and all ok signals = 0 for every cycle.
